// File: rtl/counter_bcd.sv
// Multi-decade packed-BCD up/down counter with synchronous load, wrap or
// saturate overflow handling, and registered carry/borrow pulses.
module counter_bcd #(
    parameter int P_DIGITS = 4,
    parameter bit P_SAT    = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [4*P_DIGITS-1:0] i_val,
    input  logic                  i_inc,
    input  logic                  i_dec,
    output logic [4*P_DIGITS-1:0] o_val,
    output logic                  o_inc,
    output logic                  o_dec,
    output logic                  o_zero,
    output logic                  o_max
);

    localparam int              W         = 4 * P_DIGITS;
    localparam logic [W-1:0]    ALL_NINES = {P_DIGITS{4'h9}};

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] inc_val, dec_val, load_val;
    logic         inc_q, inc_d, dec_q, dec_d;
    logic         carry_out, borrow_out;

    // Decade ripple: carry_out/borrow_out survive only when every digit
    // was 9 / 0, so they double as the all-nines / all-zero detectors.
    always_comb begin : ripple
        logic       c, b;
        logic [3:0] di, dd, dl;
        // NOTE: every comb output and local gets a default before any
        // conditional assignment so no path can infer a latch.
        inc_val  = cnt_q;
        dec_val  = cnt_q;
        load_val = '0;
        c        = 1'b1;
        b        = 1'b1;
        di       = '0;
        dd       = '0;
        dl       = '0;
        for (int k = 0; k < P_DIGITS; k++) begin
            di = cnt_q[4*k +: 4];
            dd = cnt_q[4*k +: 4];
            dl = i_val[4*k +: 4];
            if (c) begin
                if (di == 4'd9) begin
                    inc_val[4*k +: 4] = 4'd0;
                end else begin
                    inc_val[4*k +: 4] = di + 4'd1;
                    c = 1'b0;
                end
            end
            if (b) begin
                if (dd == 4'd0) begin
                    dec_val[4*k +: 4] = 4'd9;
                end else begin
                    dec_val[4*k +: 4] = dd - 4'd1;
                    b = 1'b0;
                end
            end
            load_val[4*k +: 4] = (dl > 4'd9) ? 4'd9 : dl;
        end
        carry_out  = c;
        borrow_out = b;
    end

    always_comb begin : next_state
        cnt_d = cnt_q;
        inc_d = 1'b0;
        dec_d = 1'b0;
        if (i_load) begin
            cnt_d = load_val;
        end else if (i_inc && !i_dec) begin
            inc_d = carry_out;
            if (!(carry_out && P_SAT)) cnt_d = inc_val;
        end else if (i_dec && !i_inc) begin
            dec_d = borrow_out;
            if (!(borrow_out && P_SAT)) cnt_d = dec_val;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
            inc_q <= 1'b0;
            dec_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            inc_q <= inc_d;
            dec_q <= dec_d;
        end
    end

    assign o_val  = cnt_q;
    assign o_inc  = inc_q;
    assign o_dec  = dec_q;
    assign o_zero = (cnt_q == '0);
    assign o_max  = (cnt_q == ALL_NINES);

endmodule

// File: tb/tb_counter_bcd.sv
// Self-checking bench: four counter_bcd configurations share one stimulus
// stream and are compared against an integer-arithmetic reference model.
module tb_counter_bcd;

    logic        clk;
    logic        rst;
    logic        load, inc, dec;
    logic [15:0] val;

    wire  [15:0] v0, v1;
    wire  [7:0]  v2;
    wire  [11:0] v3;
    wire  [3:0]  oi, od, oz, om;

    int n_cmp = 0;
    int n_err = 0;

    // Instance 0: 4 digits wrap, 1: 4 digits saturate, 2: 2 digits, 3: 3 digits.
    counter_bcd #(.P_DIGITS(4), .P_SAT(1'b0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_val(val),
        .i_inc(inc), .i_dec(dec), .o_val(v0), .o_inc(oi[0]), .o_dec(od[0]),
        .o_zero(oz[0]), .o_max(om[0]));
    counter_bcd #(.P_DIGITS(4), .P_SAT(1'b1)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_val(val),
        .i_inc(inc), .i_dec(dec), .o_val(v1), .o_inc(oi[1]), .o_dec(od[1]),
        .o_zero(oz[1]), .o_max(om[1]));
    counter_bcd #(.P_DIGITS(2), .P_SAT(1'b0)) u_d2 (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_val(val[7:0]),
        .i_inc(inc), .i_dec(dec), .o_val(v2), .o_inc(oi[2]), .o_dec(od[2]),
        .o_zero(oz[2]), .o_max(om[2]));
    counter_bcd #(.P_DIGITS(3), .P_SAT(1'b0)) u_d3 (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_val(val[11:0]),
        .i_inc(inc), .i_dec(dec), .o_val(v3), .o_inc(oi[3]), .o_dec(od[3]),
        .o_zero(oz[3]), .o_max(om[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: count held as a plain integer 0 .. 10^n-1.
    int m_val[4];
    bit m_inc[4];
    bit m_dec[4];

    function automatic int nd(int k);
        case (k)
            0, 1:    return 4;
            2:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int pow10(int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int load_int(logic [15:0] v, int n);
        int r = 0;
        int d;
        for (int i = n - 1; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(int v, int n);
        logic [15:0] r = '0;
        int          x = v;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] got_val(int k);
        case (k)
            0:       return v0;
            1:       return v1;
            2:       return {8'h0, v2};
            default: return {4'h0, v3};
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_val[k] = 0;
            m_inc[k] = 1'b0;
            m_dec[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        int mx;
        for (int k = 0; k < 4; k++) begin
            mx       = pow10(nd(k)) - 1;
            m_inc[k] = 1'b0;
            m_dec[k] = 1'b0;
            if (load) begin
                m_val[k] = load_int(val, nd(k));
            end else if (inc && !dec) begin
                if (m_val[k] == mx) begin
                    m_inc[k] = 1'b1;
                    if (k != 1) m_val[k] = 0;
                end else begin
                    m_val[k] = m_val[k] + 1;
                end
            end else if (dec && !inc) begin
                if (m_val[k] == 0) begin
                    m_dec[k] = 1'b1;
                    if (k != 1) m_val[k] = mx;
                end else begin
                    m_val[k] = m_val[k] - 1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int mx;
        for (int k = 0; k < 4; k++) begin
            mx = pow10(nd(k)) - 1;
            check($sformatf("val[%0d]", k),  32'(got_val(k)), 32'(to_bcd(m_val[k], nd(k))));
            check($sformatf("inc[%0d]", k),  32'(oi[k]), 32'(m_inc[k]));
            check($sformatf("dec[%0d]", k),  32'(od[k]), 32'(m_dec[k]));
            check($sformatf("zero[%0d]", k), 32'(oz[k]), 32'(m_val[k] == 0));
            check($sformatf("max[%0d]", k),  32'(om[k]), 32'(m_val[k] == mx));
        end
    endtask

    // Drive a command, let one edge take it, then compare 1 time unit later.
    task automatic step(input logic l, input logic i, input logic d, input logic [15:0] v);
        load = l;
        inc  = i;
        dec  = d;
        val  = v;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Async reset asserted between edges, commands held active through one
    // edge under reset, released on a falling edge, then one increment.
    task automatic mid_reset(input string tag);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        check({tag, "_zero_now"}, 32'(v0), 32'h0);
        load = 1'b0;
        inc  = 1'b1;
        dec  = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b0, 16'h0);
        check({tag, "_resume"}, 32'(v0), 32'h0001);
    endtask

    typedef struct {
        logic        l, i, d;
        logic [15:0] v;
        logic [15:0] ev;
        logic        ei, ed, ez, em;
    } vec_t;

    vec_t tbl[14];

    int   pulses;
    int   bad_digits;
    int   sel;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0999, 16'h0999, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h9999, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h9999, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h1233, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 16'h1200, 16'h1200, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h1199, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 16'hFA3C, 16'h9939, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};

        rst  = 1'b1;
        load = 1'b0;
        inc  = 1'b0;
        dec  = 1'b0;
        val  = '0;
        model_reset();

        // Power-on reset, with commands ignored across an edge.
        #1 rst = 1'b0;
        #1;
        check_all();
        inc = 1'b1;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Directed table on the 4-digit wrap instance (others via the model).
        for (int t = 0; t < 14; t++) begin
            step(tbl[t].l, tbl[t].i, tbl[t].d, tbl[t].v);
            check($sformatf("tbl%0d_val", t),  32'(v0),    32'(tbl[t].ev));
            check($sformatf("tbl%0d_inc", t),  32'(oi[0]), 32'(tbl[t].ei));
            check($sformatf("tbl%0d_dec", t),  32'(od[0]), 32'(tbl[t].ed));
            check($sformatf("tbl%0d_zero", t), 32'(oz[0]), 32'(tbl[t].ez));
            check($sformatf("tbl%0d_max", t),  32'(om[0]), 32'(tbl[t].em));
        end

        // Saturating instance held at all-nines with continuous increment.
        step(1'b1, 1'b0, 1'b0, 16'h9999);
        for (int t = 0; t < 3; t++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0);
            check("sat_hold_val", 32'(v1), 32'h9999);
            check("sat_inc_high", 32'(oi[1]), 32'h1);
        end
        step(1'b0, 1'b0, 1'b0, 16'h0);
        check("sat_inc_drop", 32'(oi[1]), 32'h0);

        // Two-digit: clamped load beats a same-cycle increment; inc+dec holds.
        step(1'b1, 1'b1, 1'b0, 16'h00AF);
        check("d2_clamp_load", 32'(v2), 32'h99);
        step(1'b0, 1'b1, 1'b1, 16'h0);
        check("d2_incdec_hold", 32'(v2), 32'h99);
        check("d2_incdec_nopulse", 32'(oi[2]), 32'h0);

        // Three-digit full sweep 000 -> 999 -> 000.
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        pulses     = 0;
        bad_digits = 0;
        for (int t = 0; t < 1000; t++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0);
            if (oi[3]) pulses++;
            for (int d = 0; d < 3; d++)
                if (v3[4*d +: 4] > 4'd9) bad_digits++;
        end
        check("d3_wrap_val", 32'(v3), 32'h000);
        check("d3_inc_pulses", 32'(pulses), 32'd1);
        check("d3_bad_digits", 32'(bad_digits), 32'd0);

        // Reset mid-count at 0457, then reset mid-pulse after an overflow.
        step(1'b1, 1'b0, 1'b0, 16'h0456);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        check("pre_rst_val", 32'(v0), 32'h0457);
        mid_reset("rst_count");
        step(1'b1, 1'b0, 1'b0, 16'h9999);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        check("pre_rst_pulse", 32'(oi[0]), 32'h1);
        mid_reset("rst_pulse");

        // Randomized commands, biased toward the overflow boundaries.
        for (int t = 0; t < 400; t++) begin
            sel = int'($urandom_range(0, 3));
            step(($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 (sel == 0) ? 16'h9999 : (sel == 1) ? 16'h0000 : 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
